// File: rtl/pipeline_pkg.sv
// rtl/pipeline_pkg.sv - shared widths and load transform codes for the load/ALU pipelines
package pipeline_pkg;

    localparam int DATA_W    = 16;
    localparam int ADDR_W    = 8;
    localparam int REG_DEPTH = 16;
    localparam int REG_AW    = 4;
    localparam int FUNC_W    = 4;

    // Codes 7..15 are reserved in the shared code space and treated as illegal here
    typedef enum logic [FUNC_W-1:0] {
        LD_WORD = 4'd0,
        LD_LOB  = 4'd1,
        LD_HIB  = 4'd2,
        LD_LOBS = 4'd3,
        LD_SHR  = 4'd4,
        LD_SHL  = 4'd5,
        LD_INV  = 4'd6
    } ld_func_e;

endpackage

// File: rtl/pipelining_load_if.sv
// rtl/pipelining_load_if.sv - request, memory-write, observe and retire signals of the load pipeline
interface pipelining_load_if;
    import pipeline_pkg::*;

    logic              valid_in;
    logic [ADDR_W-1:0] addr;
    logic [REG_AW-1:0] rd;
    logic [FUNC_W-1:0] func;
    logic              hold;
    logic              mem_we;
    logic [ADDR_W-1:0] mem_waddr;
    logic [DATA_W-1:0] mem_wdata;
    logic [REG_AW-1:0] rs_obs;
    logic [DATA_W-1:0] reg_obs;
    logic [DATA_W-1:0] Zout;
    logic              valid_out;
    logic [REG_AW-1:0] rd_out;
    logic              err;

    modport master (
        output valid_in, addr, rd, func, hold, mem_we, mem_waddr, mem_wdata, rs_obs,
        input  reg_obs, Zout, valid_out, rd_out, err
    );

    modport slave (
        input  valid_in, addr, rd, func, hold, mem_we, mem_waddr, mem_wdata, rs_obs,
        output reg_obs, Zout, valid_out, rd_out, err
    );

endinterface

// File: rtl/load_xform.sv
// rtl/load_xform.sv - combinational extract/transform of a loaded word
module load_xform
    import pipeline_pkg::*;
(
    input  logic [FUNC_W-1:0] i_func,
    input  logic [DATA_W-1:0] i_d,
    output logic [DATA_W-1:0] o_z,
    output logic              o_illegal
);

    always_comb begin
        o_z       = '0;
        o_illegal = 1'b0;
        case (i_func)
            LD_WORD: o_z = i_d;
            LD_LOB:  o_z = {8'h00, i_d[7:0]};
            LD_HIB:  o_z = {8'h00, i_d[15:8]};
            LD_LOBS: o_z = {{8{i_d[7]}}, i_d[7:0]};
            LD_SHR:  o_z = {1'b0, i_d[15:1]};
            LD_SHL:  o_z = {i_d[14:0], 1'b0};
            LD_INV:  o_z = ~i_d;
            default: o_illegal = 1'b1;
        endcase
    end

endmodule

// File: rtl/pipelining_load.sv
// rtl/pipelining_load.sv - three-stage load pipeline: data memory -> transform -> register bank
module pipelining_load #(
    parameter int ADDR_W = 8,
    parameter int DATA_W = 16
) (
    input  logic              CLK,
    input  logic              RST,
    pipelining_load_if.slave  bus
);
    import pipeline_pkg::*;

    localparam int MEM_DEPTH = 1 << ADDR_W;

    logic              r_l12_valid;
    logic [ADDR_W-1:0] r_l12_addr;
    logic [REG_AW-1:0] r_l12_rd;
    logic [FUNC_W-1:0] r_l12_func;

    logic              r_l23_valid;
    logic [DATA_W-1:0] r_l23_d;
    logic [REG_AW-1:0] r_l23_rd;
    logic [FUNC_W-1:0] r_l23_func;

    logic              r_l34_valid;
    logic [DATA_W-1:0] r_l34_z;
    logic [REG_AW-1:0] r_l34_rd;
    logic              r_l34_err;

    logic [DATA_W-1:0] r_mem      [MEM_DEPTH];
    logic [DATA_W-1:0] r_reg_bank [REG_DEPTH];

    logic [DATA_W-1:0] w_xform_z;
    logic              w_illegal;
    logic              w_retire;

    load_xform u_xform (
        .i_func    (r_l23_func),
        .i_d       (r_l23_d),
        .o_z       (w_xform_z),
        .o_illegal (w_illegal)
    );

    // Data fields shift even for bubbles; only valids and outputs are reset
    always_ff @(posedge CLK) begin
        if (RST) begin
            r_l12_valid <= 1'b0;
            r_l23_valid <= 1'b0;
            r_l34_valid <= 1'b0;
            r_l34_z     <= '0;
            r_l34_rd    <= '0;
            r_l34_err   <= 1'b0;
        end else if (!bus.hold) begin
            r_l12_valid <= bus.valid_in;
            r_l12_addr  <= bus.addr;
            r_l12_rd    <= bus.rd;
            r_l12_func  <= bus.func;
            r_l23_valid <= r_l12_valid;
            r_l23_d     <= r_mem[r_l12_addr];
            r_l23_rd    <= r_l12_rd;
            r_l23_func  <= r_l12_func;
            r_l34_valid <= r_l23_valid;
            r_l34_z     <= w_xform_z;
            r_l34_rd    <= r_l23_rd;
            r_l34_err   <= r_l23_valid & w_illegal;
        end
    end

    // Stage 3 only advances when hold is low, so each load retires exactly once
    assign w_retire = r_l34_valid & ~r_l34_err & ~bus.hold;

    always_ff @(posedge CLK) begin
        if (RST) begin
            for (int i = 0; i < REG_DEPTH; i++) begin
                r_reg_bank[i] <= '0;
            end
        end else if (w_retire) begin
            r_reg_bank[r_l34_rd] <= r_l34_z;
        end
    end

    // Memory ignores reset and hold; the stage-2 read sees pre-write data on a collision
    always_ff @(posedge CLK) begin
        if (bus.mem_we) begin
            r_mem[bus.mem_waddr] <= bus.mem_wdata;
        end
    end

    assign bus.reg_obs   = r_reg_bank[bus.rs_obs];
    assign bus.Zout      = r_l34_z;
    assign bus.valid_out = r_l34_valid;
    assign bus.rd_out    = r_l34_rd;
    assign bus.err       = r_l34_err;

endmodule

// File: tb/tb_pipelining_load.sv
// tb/tb_pipelining_load.sv - directed-vector bench for pipelining_load
module tb_pipelining_load;

    logic CLK = 1'b0;
    logic RST = 1'b1;
    int   n_vec  = 0;
    int   n_miss = 0;
    logic [15:0] sweep_exp [6];
    logic [15:0] v;

    pipelining_load_if bus();

    pipelining_load #(.ADDR_W(8), .DATA_W(16)) dut (
        .CLK (CLK),
        .RST (RST),
        .bus (bus)
    );

    always #5 CLK = ~CLK;

    task automatic check_vec(input string tag, input logic [15:0] got, input logic [15:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_miss++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    task automatic step();
        @(posedge CLK);
        #1;
    endtask

    task automatic issue(input logic [7:0] a, input logic [3:0] r, input logic [3:0] f);
        bus.valid_in = 1'b1;
        bus.addr     = a;
        bus.rd       = r;
        bus.func     = f;
    endtask

    task automatic idle();
        bus.valid_in = 1'b0;
    endtask

    task automatic mem_write(input logic [7:0] a, input logic [15:0] d);
        bus.mem_we    = 1'b1;
        bus.mem_waddr = a;
        bus.mem_wdata = d;
        step();
        bus.mem_we    = 1'b0;
    endtask

    task automatic obs(input logic [3:0] r, output logic [15:0] val);
        bus.rs_obs = r;
        #1;
        val = bus.reg_obs;
    endtask

    task automatic check_out(input string tag, input logic [15:0] z, input logic [3:0] r,
                             input logic vo, input logic e);
        check_vec({tag, "_z"},     bus.Zout,      z);
        check_vec({tag, "_rd"},    16'(bus.rd_out), 16'(r));
        check_vec({tag, "_valid"}, 16'(bus.valid_out), 16'(vo));
        check_vec({tag, "_err"},   16'(bus.err), 16'(e));
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1);
    end

    initial begin
        sweep_exp = '{16'h00F1, 16'h0080, 16'hFFF1, 16'h4078, 16'h01E2, 16'h7F0E};
        bus.valid_in = 1'b0; bus.addr = '0; bus.rd = '0; bus.func = '0;
        bus.hold = 1'b0; bus.mem_we = 1'b0; bus.mem_waddr = '0; bus.mem_wdata = '0;
        bus.rs_obs = '0;

        // reset state
        step(); step();
        check_out("reset", 16'h0000, 4'd0, 1'b0, 1'b0);
        obs(4'd0, v);  check_vec("reset_obs0", v, 16'h0000);
        obs(4'd15, v); check_vec("reset_obs15", v, 16'h0000);

        // preload while still in reset: memory writes are not blocked by RST
        mem_write(8'h10, 16'hA5C3);
        mem_write(8'h20, 16'h80F1);
        mem_write(8'h30, 16'h1111);
        mem_write(8'h40, 16'h1234);
        mem_write(8'h41, 16'h5678);
        mem_write(8'h42, 16'h9ABC);
        RST = 1'b0;

        // basic load
        issue(8'h10, 4'd3, 4'd0); step();
        idle(); step(); step();
        check_out("basic", 16'hA5C3, 4'd3, 1'b1, 1'b0);
        step();
        obs(4'd3, v); check_vec("basic_reg3", v, 16'hA5C3);
        check_vec("basic_bubble_valid", 16'(bus.valid_out), 16'h0000);

        // back-to-back transform sweep, rd = func
        for (int i = 0; i < 9; i++) begin
            if (i < 6) issue(8'h20, 4'(i + 1), 4'(i + 1));
            else       idle();
            step();
            if (i >= 2 && i < 8)
                check_out($sformatf("sweep%0d", i - 1), sweep_exp[i - 2], 4'(i - 1), 1'b1, 1'b0);
        end
        for (int r = 1; r <= 6; r++) begin
            obs(4'(r), v);
            check_vec($sformatf("sweep_reg%0d", r), v, sweep_exp[r - 1]);
        end

        // illegal code: zero result, err, no register write
        issue(8'h20, 4'd5, 4'd9); step();
        idle(); step(); step();
        check_out("illegal", 16'h0000, 4'd5, 1'b1, 1'b1);
        step();
        obs(4'd5, v); check_vec("illegal_reg5", v, 16'h01E2);
        check_vec("illegal_err_clear", 16'(bus.err), 16'h0000);

        // read/write collision while the first load is in stage 2
        issue(8'h30, 4'd7, 4'd0); step();
        issue(8'h30, 4'd8, 4'd0);
        bus.mem_we = 1'b1; bus.mem_waddr = 8'h30; bus.mem_wdata = 16'h2222;
        step();
        idle(); bus.mem_we = 1'b0;
        step();
        check_out("rbw_old", 16'h1111, 4'd7, 1'b1, 1'b0);
        step();
        check_out("rbw_new", 16'h2222, 4'd8, 1'b1, 1'b0);

        // hold for 4 cycles with 3 loads in flight; request during hold is ignored
        issue(8'h40, 4'd9, 4'd0);  step();
        issue(8'h41, 4'd10, 4'd0); step();
        issue(8'h42, 4'd11, 4'd0); step();
        check_out("hold_pre", 16'h1234, 4'd9, 1'b1, 1'b0);
        bus.hold = 1'b1;
        issue(8'h10, 4'd12, 4'd0);
        for (int k = 0; k < 4; k++) begin
            step();
            check_out($sformatf("hold%0d", k), 16'h1234, 4'd9, 1'b1, 1'b0);
        end
        obs(4'd9, v); check_vec("hold_reg9_frozen", v, 16'h0000);
        bus.hold = 1'b0;
        idle();
        step(); check_out("hold_rel1", 16'h5678, 4'd10, 1'b1, 1'b0);
        step(); check_out("hold_rel2", 16'h9ABC, 4'd11, 1'b1, 1'b0);
        step(); check_vec("hold_rel3_valid", 16'(bus.valid_out), 16'h0000);
        step();
        obs(4'd9, v);  check_vec("hold_reg9", v, 16'h1234);
        obs(4'd10, v); check_vec("hold_reg10", v, 16'h5678);
        obs(4'd11, v); check_vec("hold_reg11", v, 16'h9ABC);
        obs(4'd12, v); check_vec("hold_reg12", v, 16'h0000);

        // reset with 3 loads in flight
        issue(8'h10, 4'd1, 4'd0); step();
        issue(8'h20, 4'd2, 4'd1); step();
        issue(8'h30, 4'd3, 4'd0); step();
        check_out("rst_pre", 16'hA5C3, 4'd1, 1'b1, 1'b0);
        RST = 1'b1;
        issue(8'h42, 4'd4, 4'd0);
        step();
        check_out("rst_mid", 16'h0000, 4'd0, 1'b0, 1'b0);
        for (int r = 0; r < 16; r++) begin
            obs(4'(r), v);
            check_vec($sformatf("rst_reg%0d", r), v, 16'h0000);
        end
        RST = 1'b0;
        idle();
        for (int k = 0; k < 3; k++) begin
            step();
            check_vec($sformatf("rst_drain%0d", k), 16'(bus.valid_out), 16'h0000);
        end

        // memory retained across reset
        issue(8'h10, 4'd1, 4'd0); step();
        issue(8'h30, 4'd2, 4'd0); step();
        idle(); step();
        check_out("mem_keep10", 16'hA5C3, 4'd1, 1'b1, 1'b0);
        step();
        check_out("mem_keep30", 16'h2222, 4'd2, 1'b1, 1'b0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
        $finish;
    end

endmodule

// File: doc/pipelining_load.md
# pipelining_load

Load pipeline that reads 16-bit words from a 256-entry data memory and retires them into a 16-entry register bank. It is the reader counterpart of the existing ALU/store pipeline: the ALU pipeline writes results into data memory, and this block fetches them back, optionally extracts or transforms them, and writes them into registers. It is single-clock, three register stages, and supports a global hold.

## Interface
- `ADDR_W`, 8: memory address width (256 words).
- `DATA_W`, 16: data word width.
- `CLK` input 1: single clock; all state changes on posedge.
- `RST` input 1: synchronous, active-high reset.
- `valid_in` input 1: a load request is presented this cycle.
- `addr` input 8: memory address to load.
- `rd` input 4: destination register.
- `func` input 4: load transform code.
- `hold` input 1: freeze all pipeline stages.
- `mem_we` input 1: external memory write enable, used for preload and for the store side.
- `mem_waddr` input 8: memory write address.
- `mem_wdata` input 16: memory write data.
- `rs_obs` input 4: register bank observe address.
- `reg_obs` output 16: combinational `regBank[rs_obs]`.
- `Zout` output 16: stage-3 result (`l34_z`).
- `valid_out` output 1: `Zout`/`rd_out` hold a retiring load.
- `rd_out` output 4: destination register of `Zout`.
- `err` output 1: retiring load had an illegal `func`.

## Operation
- **Stage 1 (`l12`):** capture `valid_in`, `addr`, `rd`, `func`.
- **Stage 2 (`l23`):** `l23_d <= mem[l12_addr]`; forward `valid`, `rd`, `func`.
- **Stage 3 (`l34`):** `l34_z <= xform(l23_func, l23_d)`; forward `valid` and `rd`; set `err`.
- **Retire:** on the cycle after stage 3, if `l34_valid && !err && !hold`, then `regBank[l34_rd] <= l34_z`.
- **`func` codes:**
  - 0: word.
  - 1: `{8'h00, d[7:0]}`.
  - 2: `{8'h00, d[15:8]}`.
  - 3: `{{8{d[7]}}, d[7:0]}`.
  - 4: `d >> 1` (logical).
  - 5: `d << 1`, bit 15 discarded.
  - 6: `~d`.
  - 7–15: illegal. The result is `16'h0000` and `err = 1` with `valid_out = 1`, and no register write occurs.
- **Memory write:** if `mem_we`, then `mem[mem_waddr] <= mem_wdata` at posedge. This takes effect regardless of `hold` and `RST`.
- **Same-cycle conflict:** a stage-2 read and a `mem_we` write to the same address in the same cycle. The read returns the old data (read-before-write).
- **Hold:** when `hold = 1`, every stage register and the retire write keep their values, and `valid_in` is ignored.
- **Bubbles:** a bubble (`valid_in = 0`) propagates as `valid = 0`. Bubbles do not update the register bank, but data fields still shift.
- **Reset:** clears all stage valids, `Zout`, `rd_out`, `err`, and every `regBank` entry to 0. Memory contents are preserved.

## Timing
- **Latency:** a request sampled at edge n appears on `Zout`/`valid_out` after edge n+2. The register bank is updated at edge n+3, and `reg_obs` reflects it after that edge.
- **Throughput:** one load per cycle when `hold = 0`.
- **Hold:** hold asserted for k cycles delays all in-flight loads by exactly k cycles. No load is lost or duplicated.
- **Back-to-back retires to the same `rd`:** the later one wins. There is no forwarding: a load reading memory written by a retire is not a hazard, because retire targets registers only.
- **Reset mid-operation:** in-flight loads are discarded, and `valid_out = 0` on the cycle after the reset edge. A request presented during reset is not captured.
- **Reset values:** `Zout = 0`, `valid_out = 0`, `rd_out = 0`, `err = 0`, `reg_obs = 0` for any `rs_obs`.

## Structure
- **Shared package `pipeline_pkg`:**
  - `func` code constants (`LD_WORD`, `LD_LOB`, `LD_HIB`, `LD_LOBS`, `LD_SHR`, `LD_SHL`, `LD_INV`).
  - `DATA_W` and register-bank depth.
  - These codes are shared with the ALU pipeline's code space.
- **Sub-module `load_xform`:** combinational; takes `func` and `d`, returns `z` and `illegal`. It is instantiated in stage 3.
- **Top level:** contains the memory, the register bank, and the stage registers.

## Test plan
- **Basic load:** preload `mem[8'h10] = 16'hA5C3`, then issue `func = 0`, `rd = 3`. Expect `Zout = A5C3` and `valid_out` 3 cycles after issue; `reg_obs(3) = A5C3` one cycle later.
- **Transform sweep on `mem[8'h20] = 16'h80F1`:**
  - `func` 1 gives `00F1`.
  - `func` 2 gives `0080`.
  - `func` 3 gives `FFF1`.
  - `func` 4 gives `4078`.
  - `func` 5 gives `01E2`.
  - `func` 6 gives `7F0E`.
  - Issue these back-to-back and expect one result per cycle.
- **Illegal code:** `func = 9` with `rd = 5`. Expect `err = 1`, `Zout = 0`, and `regBank[5]` unchanged.
- **Read/write conflict:** `mem[8'h30] = 1111`. Write `2222` to `8'h30` in the same cycle that the load is in stage 2. Expect the load to return `1111`, and a following load to return `2222`.
- **Hold:** assert `hold` for 4 cycles with 3 loads in flight. Expect outputs frozen, then resuming in order with no drops.
- **Reset mid-flight:** apply `RST` with 3 loads in flight. Expect `valid_out = 0`, all registers at 0, and memory retaining its preloaded values.
